pwm_meas: RTL and testbench
===========================

PWM_MEAS -- requirements
Module: pwm_meas

Interface
REQ-001 Parameter CW, default 8: width of all measurement counters and result outputs.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 pwm_in  input  4  PWM channels from the upstream PWM generator; asynchronous to clk.
REQ-005 ch_sel  input  2  channel to measure; sampled only when a start is accepted.
REQ-006 start  input  1  single-cycle measurement request.
REQ-007 busy  output  1  high while a measurement is in progress.
REQ-008 done  output  1  one-cycle pulse marking result or error completion.
REQ-009 err  output  1  timeout flag; valid with done and held until the next accepted start.
REQ-010 high_cnt  output  CW  measured high time of the last successful measurement, in clk cycles.
REQ-011 period_cnt  output  CW  measured period of the last successful measurement, in clk cycles.

Function
REQ-012 Each pwm_in bit SHALL pass through a 2-flop synchronizer; the selected synced bit plus one delay flop SHALL provide rise and fall detection (rise = synced 1 and previous 0).
REQ-013 The FSM SHALL have exactly the states IDLE, WAIT_RISE, MEAS_HIGH and MEAS_LOW.
REQ-014 IDLE: start=1 SHALL latch ch_sel, clear err and the wait counter, and go to WAIT_RISE; busy SHALL be 1 from the next cycle.
REQ-015 start SHALL be ignored while busy=1; ch_sel changes after acceptance SHALL have no effect.
REQ-016 WAIT_RISE: on rise, go to MEAS_HIGH with high accumulator=1 and period accumulator=0; otherwise the wait counter SHALL increment.
REQ-017 MEAS_HIGH: period accumulator +1 every cycle; high accumulator +1 while synced input=1; on fall, go to MEAS_LOW.
REQ-018 MEAS_LOW: period accumulator +1 every cycle; on rise, period_cnt SHALL be loaded with period accumulator+1 and high_cnt with the high accumulator; done SHALL be set to 1 for the next cycle only, busy SHALL be cleared and the FSM SHALL return to IDLE.
REQ-019 Timeout: the wait counter or period accumulator reaching 2^CW-1 SHALL end the measurement with done=1 and err=1 for one cycle, busy cleared and return to IDLE; high_cnt and period_cnt SHALL retain their prior values.
REQ-020 A constant-high or constant-low input SHALL therefore always terminate by timeout; the FSM SHALL never hang.
REQ-021 Counters SHALL saturate and never wrap.
REQ-022 start SHALL be accepted in the same cycle that done=1 is shown.
REQ-023 Latency from the measured edge to done is 3 to 4 clk cycles: 2 synchronizer cycles plus registered FSM output.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE; busy, done, err, high_cnt, period_cnt, all counters and synchronizer flops SHALL be 0.
REQ-025 Reset asserted mid-measurement SHALL abort with no done pulse; after release the block SHALL accept a new start normally.

Verification
REQ-026 Upstream PWM with a 101-cycle period and 25 high cycles on ch0, start with ch_sel=0 -> one done pulse, err=0, high_cnt=25, period_cnt=101.
REQ-027 Same generator, ch_sel=1/2/3 in turn -> high_cnt=50/75/95, period_cnt=101 each, err=0.
REQ-028 pwm_in[2] held at 0, start with ch_sel=2 -> done with err=1 after 255 wait cycles; high_cnt and period_cnt unchanged.
REQ-029 pwm_in[0] held at 1 after one rise -> done with err=1 once the period accumulator reaches 255; busy then 0.
REQ-030 start pulsed while busy, with a different ch_sel -> ignored; the result matches the originally latched channel.
REQ-031 rst_n pulsed low during MEAS_HIGH -> outputs 0 asynchronously and no done pulse; a new start then gives a correct result.

Source files
------------

// File: rtl/pwm_meas.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_meas
//  Description : Measures the high time and period of one of four asynchronous
//                PWM inputs, with a timeout for stuck or overlong waveforms.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_meas #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    pwm_in,
    input  logic [1:0]    ch_sel,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] high_cnt,
    output logic [CW-1:0] period_cnt
);

    localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};
    localparam logic [CW-1:0] c_one     = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync1_q, sync2_q;
    logic          prev_q;
    logic [1:0]    ch_q, ch_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [CW-1:0] hacc_q, hacc_d;
    logic [CW-1:0] pacc_q, pacc_d;
    logic [CW-1:0] high_q, high_d;
    logic [CW-1:0] period_q, period_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          w_sel;
    logic          w_prev_d;
    logic          w_rise;
    logic          w_fall;

    assign w_sel    = sync2_q[ch_q];
    // The delay flop follows the channel about to be used, so a freshly
    // latched channel never sees a false edge against the old one.
    assign w_prev_d = sync2_q[ch_d];
    assign w_rise   = w_sel & ~prev_q;
    assign w_fall   = ~w_sel & prev_q;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        wait_d   = wait_q;
        hacc_d   = hacc_q;
        pacc_d   = pacc_q;
        high_d   = high_q;
        period_d = period_q;
        done_d   = 1'b0;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ch_d    = ch_sel;
                    err_d   = 1'b0;
                    wait_d  = '0;
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (w_rise) begin
                    hacc_d  = c_one;
                    pacc_d  = '0;
                    state_d = MEAS_HIGH;
                end else if (wait_q == c_cnt_max) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + c_one;
                end
            end
            MEAS_HIGH: begin
                if (pacc_q == c_cnt_max) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    pacc_d = pacc_q + c_one;
                    if (w_sel && (hacc_q != c_cnt_max)) begin
                        hacc_d = hacc_q + c_one;
                    end
                    if (w_fall) begin
                        state_d = MEAS_LOW;
                    end
                end
            end
            MEAS_LOW: begin
                // A full accumulator means the period no longer fits the result.
                if (pacc_q == c_cnt_max) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (w_rise) begin
                    period_d = pacc_q + c_one;
                    high_d   = hacc_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    pacc_d = pacc_q + c_one;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= 1'b0;
            ch_q     <= '0;
            wait_q   <= '0;
            hacc_q   <= '0;
            pacc_q   <= '0;
            high_q   <= '0;
            period_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= pwm_in;
            sync2_q  <= sync1_q;
            prev_q   <= w_prev_d;
            ch_q     <= ch_d;
            wait_q   <= wait_d;
            hacc_q   <= hacc_d;
            pacc_q   <= pacc_d;
            high_q   <= high_d;
            period_q <= period_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign high_cnt   = high_q;
    assign period_cnt = period_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_meas.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_meas
//  Description : Self-checking bench for pwm_meas driven by a programmable
//                four-channel PWM generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pwm_meas;

    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic [3:0]    pwm_in = 4'b0;
    logic [1:0]    ch_sel = 2'b0;
    logic          start  = 1'b0;
    logic          busy, done, err;
    logic [CW-1:0] high_cnt, period_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int gen_period  = 101;
    int gen_high[4] = '{25, 50, 75, 95};
    bit gen_force[4] = '{default: 1'b0};
    bit gen_fval[4]  = '{default: 1'b0};
    int gen_cnt     = 0;
    int rise_t[4]   = '{default: 0};

    int last_high   = 0;
    int last_period = 0;

    pwm_meas #(.CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .ch_sel     (ch_sel),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Upstream generator: channel c is high for gen_high[c] of every gen_period cycles.
    initial begin : gen
        logic nv;
        forever begin
            @(negedge clk);
            gen_cnt = (gen_cnt + 1 >= gen_period) ? 0 : gen_cnt + 1;
            for (int c = 0; c < 4; c++) begin
                nv = gen_force[c] ? gen_fval[c] : (gen_cnt < gen_high[c]);
                if (nv && !pwm_in[c]) rise_t[c] = cyc;
                pwm_in[c] = nv;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    function automatic bit model_ok(input int c);
        if (gen_force[c]) return 1'b0;
        if (gen_period > CMAX) return 1'b0;
        if (gen_high[c] < 1 || gen_high[c] >= gen_period) return 1'b0;
        return 1'b1;
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_meas(input int ch, input int glitch_ch, input bit pre, input bit chain,
                            input int chain_ch, input int start_lat, input int rise_lat,
                            input string name);
        bit ok;
        int exp_h, exp_p, n, rl;
        ok    = model_ok(ch);
        exp_h = ok ? gen_high[ch] : last_high;
        exp_p = ok ? gen_period   : last_period;
        if (!pre) begin
            @(negedge clk);
            ch_sel = 2'(ch);
            start  = 1'b1;
        end
        @(negedge clk);
        start  = 1'b0;
        ch_sel = ~ch_sel;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        n = 1;
        while (done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
            if (glitch_ch >= 0 && n == 2) begin
                start  = 1'b1;
                ch_sel = 2'(glitch_ch);
            end else begin
                start = 1'b0;
            end
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_timeout: got no done after %0d cycles want done", name, n);
        end else begin
            if (err !== !ok || high_cnt !== CW'(exp_h) || period_cnt !== CW'(exp_p)) begin
                miscompares++;
                $display("FAIL %s result: got err=%b high=%0d period=%0d want err=%b high=%0d period=%0d",
                         name, err, high_cnt, period_cnt, !ok, exp_h, exp_p);
            end
            rl = cyc - rise_t[ch];
            if (start_lat > 0) begin
                vectors++;
                if (n != start_lat) begin
                    miscompares++;
                    $display("FAIL %s start_to_done: got %0d want %0d", name, n, start_lat);
                end
            end
            if (rise_lat > 0) begin
                vectors++;
                if (rl != rise_lat) begin
                    miscompares++;
                    $display("FAIL %s rise_to_done: got %0d want %0d", name, rl, rise_lat);
                end
            end else if (ok) begin
                vectors++;
                if (rl < 3 || rl > 4) begin
                    miscompares++;
                    $display("FAIL %s edge_to_done: got %0d want 3..4", name, rl);
                end
            end
        end
        if (ok) begin
            last_high   = exp_h;
            last_period = exp_p;
        end
        if (chain) begin
            ch_sel = 2'(chain_ch);
            start  = 1'b1;
        end else begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0 || err !== !ok) begin
                miscompares++;
                $display("FAIL %s after_done: got done=%b busy=%b err=%b want done=0 busy=0 err=%b",
                         name, done, busy, err, !ok);
            end
        end
    endtask

    task automatic test_reset();
        settle(3);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || high_cnt !== '0 || period_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b err=%b high=%0d period=%0d want all 0",
                     busy, done, err, high_cnt, period_cnt);
        end
        rst_n = 1'b1;
        settle(4);
    endtask

    task automatic set_standard();
        gen_period = 101;
        gen_high   = '{25, 50, 75, 95};
        gen_force  = '{default: 1'b0};
        settle(gen_period + 10);
    endtask

    task automatic test_channels();
        set_standard();
        for (int c = 0; c < 4; c++) run_meas(c, -1, 0, 0, 0, 0, 0, $sformatf("ch%0d", c));
    endtask

    task automatic test_wait_timeout();
        gen_force[2] = 1'b1;
        gen_fval[2]  = 1'b0;
        settle(5);
        run_meas(2, -1, 0, 0, 0, CMAX + 2, 0, "wait_timeout");
        gen_force[2] = 1'b0;
    endtask

    task automatic test_high_timeout();
        gen_force[0] = 1'b1;
        gen_fval[0]  = 1'b0;
        settle(5);
        fork
            run_meas(0, -1, 0, 0, 0, 0, CMAX + 4, "high_timeout");
            begin
                settle(10);
                gen_fval[0] = 1'b1;
            end
        join
        gen_force[0] = 1'b0;
    endtask

    task automatic test_boundary();
        gen_period  = CMAX;
        gen_high[1] = 100;
        settle(gen_period + 10);
        run_meas(1, -1, 0, 0, 0, 0, 0, "period_max");
        gen_period = CMAX + 1;
        settle(gen_period + 10);
        run_meas(1, -1, 0, 0, 0, 0, 0, "period_over");
    endtask

    task automatic test_busy_ignore();
        set_standard();
        run_meas(1, 3, 0, 0, 0, 0, 0, "start_while_busy");
    endtask

    task automatic test_back_to_back();
        run_meas(0, -1, 0, 1, 2, 0, 0, "b2b_first");
        run_meas(2, -1, 1, 0, 0, 0, 0, "b2b_second");
    endtask

    task automatic test_reset_mid();
        int r0, k;
        set_standard();
        r0 = rise_t[3];
        @(negedge clk);
        ch_sel = 2'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (rise_t[3] == r0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        settle(8);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || high_cnt !== '0 || period_cnt !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got busy=%b done=%b err=%b high=%0d period=%0d want all 0",
                     busy, done, err, high_cnt, period_cnt);
        end
        last_high   = 0;
        last_period = 0;
        settle(3);
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) k++;
        end
        vectors++;
        if (k != 0) begin
            miscompares++;
            $display("FAIL no_done_after_reset: got %0d active cycles want 0", k);
        end
        run_meas(3, -1, 0, 0, 0, 0, 0, "after_reset");
    endtask

    task automatic test_random();
        int ch;
        for (int it = 0; it < 8; it++) begin
            gen_period = (it < 6) ? int'($urandom_range(20, 240)) : int'($urandom_range(260, 320));
            for (int c = 0; c < 4; c++) gen_high[c] = int'($urandom_range(1, gen_period - 1));
            ch = int'($urandom_range(0, 3));
            settle(gen_period + 10);
            run_meas(ch, -1, 0, 0, 0, 0, 0, $sformatf("random%0d", it));
        end
    endtask

    initial begin
        test_reset();
        test_channels();
        test_wait_timeout();
        test_high_timeout();
        test_boundary();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
